// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store pipeline stage with request/grant/response data-memory port
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses complete with err_o instead of being masked)
module mem_access_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prev_valid_i,
  output logic              self_ready_o,
  output logic              self_valid_o,
  input  logic              next_ready_i,
  input  logic              stall_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic [XLEN-1:0]   data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              err_o
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            r_state;
  logic              r_valid;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [NB-1:0]     r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_data;
  logic [RD_W-1:0]   r_rd;
  logic              r_err;
  logic              r_is_load;
  logic [2:0]        r_funct3;
  logic [LW-1:0]     r_off;

  logic              w_accept;
  logic              w_mem;
  logic [LW-1:0]     w_off;
  logic [LW-1:0]     w_mask;
  logic [LW-1:0]     w_aoff;
  logic              w_illegal_w;
  logic              w_misal;
  logic              w_err;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [ADDR_W-1:0] w_addr_al;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_load;

  // Acceptance: a finished result may be handed off and replaced in the same cycle
  assign self_ready_o = !stall_i && ((r_state == IDLE) || ((r_state == DONE) && next_ready_i));
  assign w_accept     = prev_valid_i && self_ready_o;
  assign w_mem        = is_load_i || is_store_i;

  // Access size mask from funct3[1:0]: size-1 in bytes, truncated to the lane index width
  assign w_off       = addr_i[LW-1:0];
  assign w_mask      = LW'((4'd1 << funct3_i[1:0]) - 4'd1);
  assign w_aoff      = w_off & ~w_mask;
  assign w_illegal_w = (funct3_i == 3'b111) ||
                       ((XLEN != 64) && ((funct3_i == 3'b011) || (funct3_i == 3'b110)));
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misal     = |(w_off & w_mask);
`else
  assign w_misal     = 1'b0;
`endif
  assign w_err       = w_mem && (w_illegal_w || w_misal);
  assign w_addr_al   = {addr_i[ADDR_W-1:LW], {LW{1'b0}}};

  // Byte enables and lane-replicated store data for the incoming access
  always_comb begin
    w_be    = '0;
    w_wdata = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_be    = NB'(1) << w_aoff;
        w_wdata = {NB{wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = NB'(3) << w_aoff;
        w_wdata = {(NB/2){wdata_i[15:0]}};
      end
      2'b10: begin
        w_be    = NB'(15) << w_aoff;
        w_wdata = {(NB/4){wdata_i[31:0]}};
      end
      default: begin
        w_be    = '1;
        w_wdata = wdata_i;
      end
    endcase
  end

  // Load data: bring the addressed lane down to bit 0, then sign- or zero-extend
  assign w_shifted = dmem_rdata_i >> {r_off, 3'b000};
  always_comb begin
    w_load = w_shifted;
    case (r_funct3)
      3'b000:  w_load = XLEN'($signed(w_shifted[7:0]));
      3'b001:  w_load = XLEN'($signed(w_shifted[15:0]));
      3'b010:  w_load = XLEN'($signed(w_shifted[31:0]));
      3'b100:  w_load = XLEN'(w_shifted[7:0]);
      3'b101:  w_load = XLEN'(w_shifted[15:0]);
      3'b110:  w_load = XLEN'(w_shifted[31:0]);
      default: w_load = w_shifted;
    endcase
  end

  // Stage FSM: accept, request until granted, wait for read data, hold result until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_data    <= '0;
      r_rd      <= '0;
      r_err     <= 1'b0;
      r_is_load <= 1'b0;
      r_funct3  <= 3'b000;
      r_off     <= '0;
    end else if (w_accept) begin
      r_rd      <= rd_i;
      r_funct3  <= funct3_i;
      r_is_load <= is_load_i;
      r_off     <= w_aoff;
      if (!w_mem || w_err) begin
        r_state <= DONE;
        r_valid <= 1'b1;
        r_err   <= w_err;
        r_data  <= w_err ? '0 : wdata_i;
        r_req   <= 1'b0;
        r_we    <= 1'b0;
      end else begin
        r_state <= REQ;
        r_valid <= 1'b0;
        r_err   <= 1'b0;
        r_req   <= 1'b1;
        r_we    <= is_store_i;
        r_addr  <= w_addr_al;
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
    end else begin
      case (r_state)
        REQ: begin
          if (dmem_gnt_i) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (r_is_load) begin
              r_state <= WAIT;
            end else begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_data  <= '0;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            r_state <= DONE;
            r_valid <= 1'b1;
            r_data  <= w_load;
          end
        end
        DONE: begin
          if (next_ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign self_valid_o = r_valid;
  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;
  assign data_o       = r_data;
  assign rd_o         = r_rd;
  assign err_o        = r_err;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Parametrised load/store pipeline stage between execute and writeback.
- Accepts one instruction per valid/ready handshake and drives a request/grant/response data-memory port.
- Handles byte-lane alignment, byte enables, sign/zero extension, and passes non-memory results through.
- One outstanding memory transaction at most; output is registered and held until the consumer takes it.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; byte lanes NB = XLEN/8, lane index width LW = log2(NB).
- ADDR_W, 32, memory address width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- prev_valid_i  in  1  upstream holds a valid instruction.
- self_ready_o  out  1  stage can accept this cycle.
- self_valid_o  out  1  data_o/rd_o/err_o valid.
- next_ready_i  in  1  downstream accepts.
- stall_i  in  1  control unit stall; blocks new acceptance only.
- is_load_i  in  1  load instruction.
- is_store_i  in  1  store instruction.
- funct3_i  in  3  RISC-V width/sign code.
- addr_i  in  ADDR_W  effective address.
- wdata_i  in  XLEN  store data, or pass-through result for non-memory ops.
- rd_i  in  RD_W  destination register.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  ADDR_W  address with low LW bits forced to 0.
- dmem_be_o  out  NB  byte enables.
- dmem_wdata_o  out  XLEN  lane-shifted store data.
- dmem_gnt_i  in  1  request granted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  XLEN  read data.
- data_o  out  XLEN  load result or pass-through value.
- rd_o  out  RD_W  destination register.
- err_o  out  1  illegal width or misaligned access (see Optional Feature).

Behaviour:
- Reset: state IDLE. self_valid_o, dmem_req_o, dmem_we_o, err_o = 0. dmem_be_o, dmem_addr_o, dmem_wdata_o, data_o = 0. rd_o = 0. Reset mid-transaction abandons it; a late rvalid received in IDLE is ignored.
- self_ready_o = !stall_i && (state==IDLE || (state==DONE && next_ready_i)). Accept = prev_valid_i && self_ready_o. Accept latches funct3, addr, wdata, rd, and op kind.
- FSM states: IDLE, REQ, WAIT, DONE.
  - Accepted non-memory op, or access flagged err: go to DONE next cycle; data_o = wdata_i (0 if err); latency 1.
  - Accepted load or store: go to REQ. dmem_req_o = 1 and request fields stay stable until dmem_gnt_i.
  - REQ with gnt, store: go to DONE; data_o = 0.
  - REQ with gnt, load: go to WAIT; dmem_req_o drops.
  - WAIT with rvalid: data_o = extracted value; go to DONE. Minimum load latency is 2 cycles after accept.
  - DONE: self_valid_o = 1; outputs held while !next_ready_i. When next_ready_i: go to IDLE, or start the next accepted op in the same cycle (back-to-back, no bubble for 1-cycle ops).
- Lanes: off = addr[LW-1:0].
  - Byte: be = 1<<off.
  - Half: be = 2'b11<<off.
  - Word: be = 4'hF<<off.
  - Dword (XLEN=64 only): all ones.
  - Store data is replicated across lanes (byte x NB, half x NB/2, word x NB/4).
  - Load: rdata >> (8*off), then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU).
- Width legality: funct3 011 (LD) and 110 (LWU) are legal only when XLEN=64. 111 is always illegal. Illegal width on a load/store sets err_o with self_valid_o and issues no memory request.
- stall_i high in DONE still allows output handoff; it only blocks acceptance.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: access with off not a multiple of its size (e.g. LH at off=1, LW at off=2) issues no request, completes in 1 cycle with err_o = 1 and data_o = 0.
- Undefined: misaligned low bits are masked to the natural alignment (LH at off=3 behaves as off=2); err_o reflects only illegal width.

Test Plan:
- XLEN=32, LB addr 0x1003, rdata 0x80FF_0000, gnt on first cycle, rvalid next cycle -> be=4'b1000, data_o=0xFFFF_FF80, self_valid_o 2 cycles after accept.
- SH addr 0x2002 wdata 0x0000_BEEF -> dmem_we_o=1, be=4'b1100, dmem_wdata_o=0xBEEF_BEEF, addr 0x2000; DONE after gnt.
- Non-memory op stream of 4 with next_ready_i=1 -> 4 consecutive valid outputs, no bubbles; rd_o follows rd_i.
- LW with gnt held low 3 cycles -> req/addr/be stable 3 cycles; next_ready_i=0 for 2 cycles in DONE -> data_o held, self_ready_o=0.
- Reset asserted in WAIT, then rvalid pulse -> outputs at reset values, no self_valid_o.
- With MEM_MISALIGN_TRAP_EN, LW addr 0x3002 -> no dmem_req_o, err_o=1, data_o=0; without the macro -> request at 0x3000, be=4'hF.
